// File: rtl/ship_amount_selector.sv
// rtl/ship_amount_selector.sv - button debounce/edge detect and ship-count selection FSM
// Produces a bounded ship count and an active-low confirm for the decision-state logic.
module ship_amount_selector #(
    parameter int MIN_SHIPS       = 1,
    parameter int MAX_SHIPS       = 5,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_confirm,
    input  logic       decision_state,
    output logic [2:0] player_amount_ships,
    output logic       player_confirm_amount,
    output logic       selecting
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0] MIN_CNT = 3'(MIN_SHIPS);
    localparam logic [2:0] MAX_CNT = 3'(MAX_SHIPS);

    typedef enum logic [1:0] {IDLE, SELECT, CONFIRMED} state_t;

    logic [2:0]         raw;
    logic [2:0]         sync_q1;
    logic [2:0]         sync_q2;
    logic [2:0]         deb_level;
    logic [2:0]         deb_prev;
    logic [2:0]         armed;
    logic [2:0]         press_evt;
    logic [2:0][CW-1:0] deb_cnt;
    logic [1:0]         warm_cnt;
    logic               warm;

    state_t     state;
    state_t     state_next;
    logic [2:0] count_next;
    logic       up_evt;
    logic       down_evt;
    logic       conf_evt;

    assign raw      = {btn_confirm, btn_down, btn_up};
    assign warm     = (warm_cnt == 2'd2);
    assign up_evt   = press_evt[0];
    assign down_evt = press_evt[1];
    assign conf_evt = press_evt[2];

    // A button is armed only once it has been seen released after reset, so a
    // button held across reset release cannot produce an event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1   <= '0;
            sync_q2   <= '0;
            deb_level <= '0;
            deb_prev  <= '0;
            armed     <= '0;
            press_evt <= '0;
            deb_cnt   <= '0;
            warm_cnt  <= '0;
        end else begin
            sync_q1   <= raw;
            sync_q2   <= sync_q1;
            deb_prev  <= deb_level;
            press_evt <= deb_level & ~deb_prev & armed;
            armed     <= armed | ({3{warm}} & ~sync_q2);
            if (!warm) begin
                warm_cnt <= warm_cnt + 2'd1;
            end
            for (int i = 0; i < 3; i++) begin
                if (sync_q2[i] == deb_level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_LAST) begin
                    deb_level[i] <= sync_q2[i];
                    deb_cnt[i]   <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        count_next = player_amount_ships;
        case (state)
            IDLE: begin
                if (decision_state) begin
                    state_next = SELECT;
                    count_next = MIN_CNT;
                end
            end
            SELECT: begin
                if (!decision_state) begin
                    state_next = IDLE;
                end else if (conf_evt) begin
                    state_next = CONFIRMED;
                end else if (up_evt && !down_evt) begin
                    if (player_amount_ships < MAX_CNT) begin
                        count_next = player_amount_ships + 3'd1;
                    end
                end else if (down_evt && !up_evt) begin
                    if (player_amount_ships > MIN_CNT) begin
                        count_next = player_amount_ships - 3'd1;
                    end
                end
            end
            CONFIRMED: begin
                if (!decision_state) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= IDLE;
            player_amount_ships   <= '0;
            selecting             <= 1'b0;
            player_confirm_amount <= 1'b1;
        end else begin
            state                 <= state_next;
            player_amount_ships   <= count_next;
            selecting             <= (state_next == SELECT);
            player_confirm_amount <= (state_next != CONFIRMED);
        end
    end
endmodule
